// File: rtl/flip_board_sched_pkg.sv
// Shared Othello types for the move-search datapath.
//   board_t     : 64-bit board, bit index = row*8+col
//   sq_t        : 6-bit square index {row[5:3], col[2:0]}
//   line_e      : line through a square (row, column, diagonal, anti-diagonal)
//   fbs_state_e : flip_board_sched FSM states
package othello_pkg;

  typedef logic [63:0] board_t;
  typedef logic [5:0]  sq_t;

  typedef enum logic [1:0] {
    LINE_ROW,
    LINE_COL,
    LINE_DIAG,
    LINE_ANTI
  } line_e;

  typedef enum logic [1:0] {
    FBS_IDLE,
    FBS_ISSUE,
    FBS_DRAIN,
    FBS_DONE
  } fbs_state_e;

endpackage

// File: rtl/flip_board_sched_if.sv
// Request/response bundle for flip_board_sched.
//   request : in_valid/in_ready, player, opponent, pos
//   response: out_valid/out_ready, flip, illegal
// slave = the scheduler, master = the move-search control driving it.
interface flip_board_sched_if;
  import othello_pkg::*;

  logic   in_valid;
  logic   in_ready;
  board_t player;
  board_t opponent;
  sq_t    pos;
  logic   out_valid;
  logic   out_ready;
  board_t flip;
  logic   illegal;

  modport slave (
    input  in_valid, player, opponent, pos, out_ready,
    output in_ready, out_valid, flip, illegal
  );

  modport master (
    output in_valid, player, opponent, pos, out_ready,
    input  in_ready, out_valid, flip, illegal
  );

endinterface

// File: rtl/flip_board_sched_flip8.sv
// flip8: 8-square line-flip engine with one registered cycle of latency.
//   clock, reset_n : clock, async active-low reset
//   p, o           : own / opponent discs along the line
//   lpos           : move position on the line
//   flip_upper     : discs flipped walking towards bit 7 (registered)
//   flip_lower     : discs flipped walking towards bit 0 (registered)
// A run of opponent discs flips only when closed by an own disc.
module flip8 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] p,
  input  logic [7:0] o,
  input  logic [2:0] lpos,
  output logic [7:0] flip_upper,
  output logic [7:0] flip_lower
);

  logic [7:0] up_c;
  logic [7:0] lo_c;

  always_comb begin : walk
    logic [7:0] run;
    logic       open;
    logic       hit;
    logic [2:0] idx;
    up_c = '0;
    lo_c = '0;

    run = '0; open = 1'b1; hit = 1'b0; idx = '0;
    for (int unsigned d = 1; d < 8; d++) begin
      if (open && (int'(lpos) + int'(d) <= 7)) begin
        idx = lpos + 3'(d);
        if (o[idx]) run[idx] = 1'b1;
        else begin
          hit  = p[idx];
          open = 1'b0;
        end
      end
    end
    up_c = hit ? run : '0;

    run = '0; open = 1'b1; hit = 1'b0;
    for (int unsigned d = 1; d < 8; d++) begin
      if (open && (int'(lpos) >= int'(d))) begin
        idx = lpos - 3'(d);
        if (o[idx]) run[idx] = 1'b1;
        else begin
          hit  = p[idx];
          open = 1'b0;
        end
      end
    end
    lo_c = hit ? run : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flip_upper <= '0;
      flip_lower <= '0;
    end else begin
      flip_upper <= up_c;
      flip_lower <= lo_c;
    end
  end

endmodule

// File: rtl/flip_board_sched.sv
// flip_board_sched: time-multiplexes one flip8 over the four lines through a
// move square and collects the full 64-bit flip mask.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : in_valid/in_ready + player/opponent/pos request,
//                    out_valid/out_ready + flip/illegal response
// Optional: define FLIP_BOARD_SCHED_ILLEGAL_CHK_EN to build the illegal-move
// flag (occupied square or empty flip); otherwise illegal is tied 0.
module flip_board_sched
  import othello_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  flip_board_sched_if.slave bus
);

  localparam int unsigned NLINES = 4;

  // Square of bit i on line ln through p; returns 0 when off-board.
  function automatic logic on_board(input line_e ln, input sq_t p,
                                    input int unsigned i, output sq_t s);
    int row, col, r, c;
    row = int'(p[5:3]);
    col = int'(p[2:0]);
    r = row; c = int'(i);
    case (ln)
      LINE_ROW:  begin r = row;                c = int'(i); end
      LINE_COL:  begin r = int'(i);            c = col;     end
      LINE_DIAG: begin r = int'(i) + row - col; c = int'(i); end
      default:   begin r = row + col - int'(i); c = int'(i); end
    endcase
    s = sq_t'(r * 8 + c);
    return (r >= 0) && (r <= 7);
  endfunction

  function automatic logic [7:0] extract(input board_t b, input line_e ln, input sq_t p);
    logic [7:0] v;
    sq_t        s;
    v = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (on_board(ln, p, i, s)) v[i] = b[s];
    return v;
  endfunction

  function automatic board_t scatter(input logic [7:0] bits, input line_e ln, input sq_t p);
    board_t v;
    sq_t    s;
    v = '0;
    for (int unsigned i = 0; i < 8; i++)
      if (on_board(ln, p, i, s) && bits[i]) v[s] = 1'b1;
    return v;
  endfunction

  fbs_state_e state;
  logic [1:0] k;
  board_t     player_q, opp_q, acc, flip_q;
  sq_t        pos_q;
  logic       col_valid;
  line_e      col_line;
  logic       out_valid_q, in_ready_q;

  line_e      issue_line;
  logic [7:0] line_p, line_o, fu, fl;
  logic [2:0] line_pos;
  board_t     acc_next;
  logic       occupied;

  assign issue_line = line_e'(k);

  always_comb begin
    line_p   = extract(player_q, issue_line, pos_q);
    line_o   = extract(opp_q, issue_line, pos_q);
    line_pos = (issue_line == LINE_COL) ? pos_q[5:3] : pos_q[2:0];
  end

  flip8 u_flip8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .p          (line_p),
    .o          (line_o),
    .lpos       (line_pos),
    .flip_upper (fu),
    .flip_lower (fl)
  );

  // flip8 result arrives one cycle after issue; col_valid/col_line track it.
  always_comb begin
    acc_next = acc;
    if (col_valid) acc_next = acc | scatter(fu | fl, col_line, pos_q);
    occupied = |((player_q | opp_q) & (board_t'(1) << pos_q));
  end

`ifdef FLIP_BOARD_SCHED_ILLEGAL_CHK_EN
  logic illegal_q;
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.flip      = flip_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FBS_IDLE;
      k           <= '0;
      player_q    <= '0;
      opp_q       <= '0;
      pos_q       <= '0;
      acc         <= '0;
      col_valid   <= 1'b0;
      col_line    <= LINE_ROW;
      flip_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef FLIP_BOARD_SCHED_ILLEGAL_CHK_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      col_valid <= (state == FBS_ISSUE);
      col_line  <= issue_line;
      acc       <= acc_next;
      case (state)
        FBS_IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            player_q   <= bus.player;
            opp_q      <= bus.opponent;
            pos_q      <= bus.pos;
            acc        <= '0;
            k          <= '0;
            in_ready_q <= 1'b0;
            state      <= FBS_ISSUE;
          end
        end
        FBS_ISSUE: begin
          k <= k + 2'd1;
          if (k == 2'(NLINES - 1)) state <= FBS_DRAIN;
        end
        FBS_DRAIN: begin
          flip_q      <= occupied ? '0 : acc_next;
          out_valid_q <= 1'b1;
`ifdef FLIP_BOARD_SCHED_ILLEGAL_CHK_EN
          illegal_q   <= occupied || (acc_next == '0);
`endif
          state       <= FBS_DONE;
        end
        default: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= FBS_IDLE;
          end
        end
      endcase
    end
  end

endmodule
